// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared state, requester ids and latched-request type for mem_port_arbiter.
package mem_port_pkg;
    localparam int MAX_ADDR_W = 64;
    localparam int MAX_DATA_W = 64;
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_LSU = 1'b1;
    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE} state_t;
    typedef struct packed {
        logic id;
        logic write;
        logic pair;
        logic beat;
        logic [MAX_ADDR_W-1:0] addr;
        logic [MAX_DATA_W-1:0] wdata0;
        logic [MAX_DATA_W-1:0] wdata1;
    } req_t;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; the most recent winner loses the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic ptr;
    always_comb gnt = !en ? 2'b00 : (&req ? (ptr ? 2'b10 : 2'b01) : req);
    always_ff @(posedge clk) begin
        if (rst) ptr <= 1'b0;
        else if (|gnt) ptr <= gnt[0];
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and LSU, one read outstanding at a time.
// Optional read watchdog with resp_err output when MEM_PORT_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int BEAT_STRIDE = 8
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req_valid,
    output logic              f_req_ready,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_resp_valid,
    output logic [DATA_W-1:0] f_resp_data,
    input  logic              l_req_valid,
    output logic              l_req_ready,
    input  logic              l_req_write,
    input  logic              l_req_pair,
    input  logic [ADDR_W-1:0] l_req_addr,
    input  logic [DATA_W-1:0] l_req_wdata0,
    input  logic [DATA_W-1:0] l_req_wdata1,
    output logic              l_resp_valid,
    output logic              l_resp_beat,
    output logic [DATA_W-1:0] l_resp_data,
    output logic              l_wr_done,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    output logic              resp_err,
`endif
    output logic [DATA_W-1:0] mem_wdata
);
    state_t state, state_n;
    req_t r;
    logic [1:0] gnt;
    logic rd_done, timed_out, more_beats;
    logic [ADDR_W-1:0] beat_addr;
    logic [DATA_W-1:0] resp_data;

    rr_arb2 u_arb (
        .clk(clk),
        .rst(rst),
        .en(state == IDLE),
        .req({l_req_valid, f_req_valid}),
        .gnt(gnt)
    );

    assign f_req_ready = gnt[0];
    assign l_req_ready = gnt[1];
    assign more_beats = r.pair && !r.beat;
    assign beat_addr = r.addr[ADDR_W-1:0] + (r.beat ? ADDR_W'(BEAT_STRIDE) : '0);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic [31:0] wait_cnt;
    assign timed_out = state == RD_WAIT && !mem_rvalid && wait_cnt == 32'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (rst || state != RD_WAIT) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + 32'd1;
    end
    always_ff @(posedge clk) resp_err <= !rst && timed_out;
`else
    assign timed_out = 1'b0;
`endif

    // Data returning alongside mem_ren counts immediately, so no beat is ever dropped.
    assign rd_done = ((state == RD_ISSUE || state == RD_WAIT) && mem_rvalid) || timed_out;

    always_comb begin
        state_n = state;
        if (state == IDLE && |gnt) state_n = (gnt[1] && l_req_write) ? WR_ISSUE : RD_ISSUE;
        else if (rd_done) state_n = more_beats ? RD_ISSUE : IDLE;
        else if (state == RD_ISSUE) state_n = RD_WAIT;
        else if (state == WR_ISSUE) state_n = more_beats ? WR_ISSUE : IDLE;
    end

    assign mem_ren = state == RD_ISSUE;
    assign mem_raddr = mem_ren ? beat_addr : '0;
    assign mem_wen = state == WR_ISSUE && r.write;
    assign mem_waddr = mem_wen ? beat_addr : '0;
    assign mem_wdata = mem_wen ? (r.beat ? r.wdata1[DATA_W-1:0] : r.wdata0[DATA_W-1:0]) : '0;
    assign l_wr_done = mem_wen && !more_beats;
    assign f_resp_data = resp_data;
    assign l_resp_data = resp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            r <= '0;
            f_resp_valid <= 1'b0;
            l_resp_valid <= 1'b0;
            l_resp_beat <= 1'b0;
            resp_data <= '0;
        end else begin
            state <= state_n;
            f_resp_valid <= rd_done && r.id == REQ_FETCH;
            l_resp_valid <= rd_done && r.id == REQ_LSU;
            l_resp_beat <= rd_done && r.beat;
            resp_data <= rd_done ? (timed_out ? '0 : mem_rdata) : resp_data;
            if (state == IDLE && |gnt)
                r <= '{id: gnt[1], write: gnt[1] & l_req_write, pair: gnt[1] & l_req_pair, beat: 1'b0,
                       addr: MAX_ADDR_W'(gnt[1] ? l_req_addr : f_req_addr),
                       wdata0: MAX_DATA_W'(l_req_wdata0), wdata1: MAX_DATA_W'(l_req_wdata1)};
            else if ((rd_done || mem_wen) && more_beats)
                r.beat <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench; each accepted request pushes its expected port/response events.
module tb_mem_port_arbiter;
    typedef struct packed {
        logic [1:0]  kind;
        logic        beat;
        logic [63:0] a;
        logic [63:0] d;
        logic        done;
    } ev_t;
    localparam logic [1:0] K_MR = 2'd0, K_MW = 2'd1, K_FR = 2'd2, K_LR = 2'd3;

    logic clk = 1'b0, rst = 1'b1;
    logic f_req_valid = 1'b0, f_req_ready, f_resp_valid;
    logic [63:0] f_req_addr = '0, f_resp_data;
    logic l_req_valid = 1'b0, l_req_ready, l_req_write = 1'b0, l_req_pair = 1'b0;
    logic [63:0] l_req_addr = '0, l_req_wdata0 = '0, l_req_wdata1 = '0;
    logic l_resp_valid, l_resp_beat, l_wr_done;
    logic [63:0] l_resp_data;
    logic mem_ren, mem_rvalid = 1'b0, mem_wen;
    logic [63:0] mem_raddr, mem_rdata = '0, mem_waddr, mem_wdata;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    logic resp_err;
`endif

    ev_t exp_q[$];
    bit grants[$];
    int n_chk = 0, n_err = 0;
    logic ptr_m = 1'b0, rv_prev = 1'b0;
    bit mem_auto = 1, spur_en = 0, manual_rv = 0, rd_pend = 0;
    int fix_lat = -1, rd_lat = 0;
    logic [63:0] rd_addr = '0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_resp_valid(f_resp_valid), .f_resp_data(f_resp_data),
        .l_req_valid(l_req_valid), .l_req_ready(l_req_ready), .l_req_write(l_req_write),
        .l_req_pair(l_req_pair), .l_req_addr(l_req_addr), .l_req_wdata0(l_req_wdata0),
        .l_req_wdata1(l_req_wdata1), .l_resp_valid(l_resp_valid), .l_resp_beat(l_resp_beat),
        .l_resp_data(l_resp_data), .l_wr_done(l_wr_done),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_wen(mem_wen), .mem_waddr(mem_waddr),
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        .resp_err(resp_err),
`endif
        .mem_wdata(mem_wdata)
    );

    // Memory contents: a few fixed words for the directed cases, a hash of the address elsewhere.
    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        if (a == 64'h1000) return 64'hDEAD;
        if (a == 64'h2000) return 64'hA;
        if (a == 64'h2008) return 64'hB;
        return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
    endfunction

    function automatic logic [63:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
    endfunction

    function automatic void push(input logic [1:0] k, input logic b, input logic [63:0] a,
                                 input logic [63:0] d, input logic dn);
        ev_t e;
        e.kind = k; e.beat = b; e.a = a; e.d = d; e.done = dn;
        exp_q.push_back(e);
    endfunction

    function automatic void chk_ev(input string nm, input ev_t g);
        ev_t e;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected output kind=%0d beat=%0d addr=%h data=%h done=%0d, nothing was required",
                     nm, g.kind, g.beat, g.a, g.d, g.done);
            return;
        end
        e = exp_q.pop_front();
        if (g != e) begin
            n_err++;
            $display("FAIL %s: got kind=%0d beat=%0d addr=%h data=%h done=%0d, required kind=%0d beat=%0d addr=%h data=%h done=%0d",
                     nm, g.kind, g.beat, g.a, g.d, g.done, e.kind, e.beat, e.a, e.d, e.done);
        end
    endfunction

    always @(posedge clk) rv_prev <= mem_rvalid;

    // Memory: answers each mem_ren after 0..3 cycles; may emit stray rvalid when nothing is pending.
    always @(negedge clk) begin
        mem_rvalid = manual_rv;
        if (manual_rv) mem_rdata = {$urandom, $urandom};
        if (!mem_auto) rd_pend = 0;
        else begin
            if (mem_ren && !rd_pend) begin
                rd_pend = 1;
                rd_addr = mem_raddr;
                rd_lat = fix_lat >= 0 ? fix_lat : int'($urandom_range(0, 3));
            end
            if (rd_pend) begin
                if (rd_lat == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = mem_fn(rd_addr);
                    rd_pend = 0;
                end else rd_lat--;
            end else if (spur_en && !mem_ren && $urandom_range(0, 7) == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Monitor: pops expectations as outputs appear, then records any request accepted this cycle.
    always @(negedge clk) begin
        logic lw;
        if (rst) begin
            exp_q.delete();
            ptr_m = 1'b0;
        end else begin
            n_chk++;
            if ((f_req_ready && l_req_ready) || (mem_ren && mem_wen) || (l_wr_done && !mem_wen)) begin
                n_err++;
                $display("FAIL port_excl: f_ready=%0d l_ready=%0d ren=%0d wen=%0d wr_done=%0d, required no overlap",
                         f_req_ready, l_req_ready, mem_ren, mem_wen, l_wr_done);
            end
            if (f_resp_valid || l_resp_valid) begin
                n_chk++;
                if (!rv_prev || (f_resp_valid && l_resp_valid)) begin
                    n_err++;
                    $display("FAIL resp_timing: rvalid_prev=%0d f_v=%0d l_v=%0d, required rvalid_prev=1 and one response",
                             rv_prev, f_resp_valid, l_resp_valid);
                end
            end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
            if (resp_err) begin
                n_err++;
                $display("FAIL resp_err: got 1, required 0");
            end
`endif
            if (f_resp_valid) chk_ev("f_resp", {K_FR, 1'b0, 64'd0, f_resp_data, 1'b0});
            if (l_resp_valid) chk_ev("l_resp", {K_LR, l_resp_beat, 64'd0, l_resp_data, 1'b0});
            if (mem_ren) chk_ev("mem_read", {K_MR, 1'b0, mem_raddr, 64'd0, 1'b0});
            if (mem_wen) chk_ev("mem_write", {K_MW, 1'b0, mem_waddr, mem_wdata, l_wr_done});
            if ((f_req_valid && f_req_ready) || (l_req_valid && l_req_ready)) begin
                lw = l_req_valid && l_req_ready;
                n_chk++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL accept_busy: accepted with %0d events outstanding, required 0", exp_q.size());
                end
                if (f_req_valid && l_req_valid) begin
                    n_chk++;
                    if (lw != ptr_m) begin
                        n_err++;
                        $display("FAIL rr_grant: granted %0d, required %0d", lw, ptr_m);
                    end
                end
                grants.push_back(lw);
                ptr_m = !lw;
                if (!lw) begin
                    push(K_MR, 1'b0, f_req_addr, 64'd0, 1'b0);
                    push(K_FR, 1'b0, 64'd0, mem_fn(f_req_addr), 1'b0);
                end else if (l_req_write) begin
                    push(K_MW, 1'b0, l_req_addr, l_req_wdata0, !l_req_pair);
                    if (l_req_pair) push(K_MW, 1'b0, l_req_addr + 64'd8, l_req_wdata1, 1'b1);
                end else begin
                    push(K_MR, 1'b0, l_req_addr, 64'd0, 1'b0);
                    push(K_LR, 1'b0, 64'd0, mem_fn(l_req_addr), 1'b0);
                    if (l_req_pair) begin
                        push(K_MR, 1'b0, l_req_addr + 64'd8, 64'd0, 1'b0);
                        push(K_LR, 1'b1, 64'd0, mem_fn(l_req_addr + 64'd8), 1'b0);
                    end
                end
            end
        end
    end

    task automatic f_req(input logic [63:0] a);
        int k;
        f_req_addr = a;
        f_req_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!f_req_ready && k < 300);
        if (!f_req_ready) begin
            n_chk++; n_err++;
            $display("FAIL f_req_wait: not accepted after %0d cycles, required acceptance", k);
        end
        @(posedge clk); #1;
        f_req_valid = 1'b0;
        f_req_addr = {$urandom, $urandom};
    endtask

    task automatic l_req(input logic w, input logic p, input logic [63:0] a,
                         input logic [63:0] d0, input logic [63:0] d1);
        int k;
        l_req_write = w; l_req_pair = p; l_req_addr = a; l_req_wdata0 = d0; l_req_wdata1 = d1;
        l_req_valid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!l_req_ready && k < 300);
        if (!l_req_ready) begin
            n_chk++; n_err++;
            $display("FAIL l_req_wait: not accepted after %0d cycles, required acceptance", k);
        end
        @(posedge clk); #1;
        l_req_valid = 1'b0;
        l_req_write = 1'($urandom); l_req_pair = 1'($urandom);
        l_req_addr = {$urandom, $urandom}; l_req_wdata0 = {$urandom, $urandom}; l_req_wdata1 = {$urandom, $urandom};
    endtask

    task automatic f_rand(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            f_req(rand_addr());
        end
    endtask

    task automatic l_rand(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            l_req(1'($urandom), 1'($urandom), rand_addr(), {$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 300) begin @(negedge clk); k++; end
        if (exp_q.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL drain: %0d events still outstanding, required 0", exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string nm);
        logic any;
        any = f_req_ready | l_req_ready | f_resp_valid | (|f_resp_data) | l_resp_valid | l_resp_beat |
              (|l_resp_data) | l_wr_done | mem_ren | (|mem_raddr) | mem_wen | (|mem_waddr) | (|mem_wdata);
        n_chk++;
        if (any) begin
            n_err++;
            $display("FAIL %s: ren=%0d wen=%0d f_v=%0d l_v=%0d wr_done=%0d f_d=%h l_d=%h raddr=%h, required all 0",
                     nm, mem_ren, mem_wen, f_resp_valid, l_resp_valid, l_wr_done, f_resp_data, l_resp_data, mem_raddr);
        end
    endtask

    initial begin
        int g0;
        logic [3:0] gs;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset_state");
        rst = 1'b0;
        fix_lat = 3;
        f_req(64'h1000);
        drain();
        fix_lat = -1;
        l_req(1'b0, 1'b1, 64'h2000, 64'd0, 64'd0);
        drain();
        l_req(1'b1, 1'b1, 64'h3000, 64'h11, 64'h22);
        drain();
        g0 = grants.size();
        fork
            begin f_req(64'h5000); f_req(64'h5100); end
            begin l_req(1'b0, 1'b0, 64'h6000, 64'd0, 64'd0); l_req(1'b1, 1'b0, 64'h6100, 64'h33, 64'h44); end
        join
        drain();
        n_chk++;
        if (grants.size() < g0 + 4) begin
            n_err++;
            $display("FAIL alternate: got %0d grants, required 4", grants.size() - g0);
        end else begin
            gs = {grants[g0], grants[g0+1], grants[g0+2], grants[g0+3]};
            if (gs != 4'b0101) begin
                n_err++;
                $display("FAIL alternate: got order %b, required 0101", gs);
            end
        end
        mem_auto = 0;
        f_req(64'h7000);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_idle("reset_in_rd_wait");
        @(posedge clk); #1;
        manual_rv = 1;
        @(posedge clk); #1;
        manual_rv = 0;
        repeat (4) begin @(posedge clk); #1; end
        chk_idle("late_rvalid_ignored");
        mem_auto = 1;
        f_req(64'h1000);
        drain();
        spur_en = 1;
        fork
            f_rand(40);
            l_rand(40);
        join
        drain();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory read/write port between two requesters: instruction fetch (requester 0, read-only) and the load/store unit (requester 1, read/write, single or paired access).
- Sequences paired accesses (ldp/stp) as two beats on the port.
- Enforces one outstanding read at a time.
- Grants round-robin between requesters; owns mem_ren/mem_wen exclusively.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width
- BEAT_STRIDE, 8, byte offset of the second beat of a paired access
- TIMEOUT_CYCLES, 255, read watchdog limit (only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- f_req_valid  in  1  fetch read request
- f_req_ready  out  1  fetch request accepted this cycle
- f_req_addr  in  ADDR_W  fetch address
- f_resp_valid  out  1  fetch read data valid (one-cycle pulse)
- f_resp_data  out  DATA_W  fetch read data
- l_req_valid  in  1  LSU request
- l_req_ready  out  1  LSU request accepted this cycle
- l_req_write  in  1  1 = store, 0 = load
- l_req_pair  in  1  1 = two-beat access
- l_req_addr  in  ADDR_W  base address
- l_req_wdata0  in  DATA_W  store data, beat 0
- l_req_wdata1  in  DATA_W  store data, beat 1
- l_resp_valid  out  1  LSU load data valid (pulse, once per beat)
- l_resp_beat  out  1  beat index of l_resp_data
- l_resp_data  out  DATA_W  LSU load data
- l_wr_done  out  1  pulse when the final store beat is issued
- mem_ren  out  1  memory read enable
- mem_raddr  out  ADDR_W  memory read address
- mem_rvalid  in  1  memory read data valid
- mem_rdata  in  DATA_W  memory read data
- mem_wen  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data

Behaviour:
- Reset:
  - All outputs are 0. FSM is IDLE.
  - Round-robin pointer is 0, so fetch is preferred first.
  - In-flight transactions are abandoned; a mem_rvalid that arrives after reset is ignored.
- Handshake:
  - A request transfers when valid && ready. ready is combinational and asserts only in IDLE for the granted requester.
  - At most one ready is high per cycle.
  - The request is latched on transfer; requester inputs may change afterwards.
- Arbitration in IDLE:
  - If only one requester is valid, it is granted.
  - If both are valid, the requester indicated by the pointer is granted. The pointer then flips to the other requester.
  - The pointer changes only on a transfer.
- FSM states:
  - IDLE -> RD_ISSUE on a read transfer; -> WR_ISSUE on a store transfer.
  - RD_ISSUE: mem_ren=1 and mem_raddr=addr for exactly one cycle, then -> RD_WAIT.
  - RD_WAIT: mem_ren=0. When mem_rvalid is seen, drive the response pulse the next cycle with registered data.
    - If a second beat remains: address += BEAT_STRIDE, -> RD_ISSUE.
    - Otherwise -> IDLE.
  - mem_rvalid in the same cycle as mem_ren is legal and is treated as arriving in RD_WAIT (no lost data).
  - WR_ISSUE: mem_wen=1 with mem_waddr/mem_wdata for one cycle per beat.
    - Beat 1 uses addr+BEAT_STRIDE and wdata1 in the following cycle.
    - l_wr_done pulses with the final beat; then -> IDLE.
  - Fetch requests are always single-beat reads.
- Latency:
  - Minimum transfer-to-mem_ren is 1 cycle.
  - Response is 1 cycle after mem_rvalid.
  - A new request can be accepted the cycle after the last response pulse or the last write beat.
- Response ordering:
  - A pair returns beat 0 then beat 1, with l_resp_beat set accordingly.
  - f_resp_* and l_resp_* are never both valid in the same cycle.
- Arithmetic: address addition wraps modulo 2^ADDR_W. No alignment check is performed.
- mem_ren and mem_wen are never high in the same cycle.
- A spurious mem_rvalid in IDLE or WR_ISSUE is ignored.

Optional Feature:
- Macro: MEM_PORT_ARB_TIMEOUT_EN.
- When defined:
  - A counter runs in RD_WAIT.
  - If TIMEOUT_CYCLES elapse without mem_rvalid, the arbiter delivers the response with data 0 and pulses an extra output, resp_err (1 bit).
  - A pair continues to its second beat after a timeout.
- When not defined: no counter and no resp_err port; RD_WAIT waits indefinitely.

Decomposition:
- Package mem_port_pkg holds:
  - the state enum (IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE)
  - requester id constants REQ_FETCH=0 and REQ_LSU=1
  - a latched-request struct {id, write, pair, beat, addr, wdata0, wdata1}
- One natural sub-module: rr_arb2, the 2-way round-robin grant with pointer register.

Test Plan:
- Fetch read of 0x1000; memory returns 0xDEAD 3 cycles after mem_ren -> one mem_ren pulse with addr 0x1000; f_resp_valid 1 cycle after mem_rvalid with 0xDEAD.
- LSU ldp at 0x2000; returns 0xA then 0xB -> mem_raddr 0x2000 then 0x2008; l_resp beat0=0xA, beat1=0xB; no fetch grant in between.
- LSU stp at 0x3000 with 0x11/0x22 -> mem_wen on two consecutive cycles (0x3000/0x11, 0x3008/0x22); l_wr_done with the second; mem_ren stays 0.
- Both requesters valid continuously for 4 transactions -> grants alternate fetch, LSU, fetch, LSU; ready is never both high.
- rst asserted in RD_WAIT, and mem_rvalid arrives 2 cycles later -> all outputs 0, no response pulse; next request is served normally.
- With MEM_PORT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, a read never answered -> response data 0 and resp_err=1 after 4 cycles in RD_WAIT; FSM returns to IDLE.
